hc32_tester: RTL and testbench
==============================

Name: hc32_tester

Overview:
- Self-test sequencer for the HC32 quad 2-input OR gate (on-chip instance or external 74HC32 on board pins).
- Drives all 256 A/B stimulus combinations (A=vec[7:4], B=vec[3:0]) into the gate array and waits a settle interval before sampling Y.
- Compares Y against A|B, accumulates a per-gate fail mask and a saturating error count, then reports pass/fail with a start/done handshake.

Parameters:
- SETTLE_CYCLES, 2: wait cycles after the synchronizer delay before sampling Y; legal range 0..15.
- ERR_W, 8: width of the error counter.

Ports:
- CLK  input  1  system clock
- RST_N  input  1  asynchronous active-low reset
- START  input  1  one-cycle request to begin a test run; honoured only in IDLE
- ABORT  input  1  synchronous abort; returns the block to IDLE
- A_OUT  output  [4:1]  registered A stimulus to the gate array
- B_OUT  output  [4:1]  registered B stimulus to the gate array
- Y_IN  input  [4:1]  gate outputs; may be asynchronous (board pins)
- BUSY  output  1  high from the cycle after START until the DONE cycle or an abort
- DONE  output  1  one-cycle pulse at end of a complete run
- PASS  output  1  result of the last complete run; held until the next START
- FAIL_MASK  output  [4:1]  bit n set if gate n mismatched on any vector
- ERR_CNT  output  [ERR_W-1:0]  number of failing vectors; saturates at all-ones
- FIRST_FAIL_VEC  output  [7:0]  first failing vector; see Optional Feature

Behaviour:
Reset (async, RST_N=0):
- All outputs 0; state IDLE; vec=0; synchronizer flops 0.

Synchronization:
- Y_IN passes through a two-flop synchronizer.
- Wait per vector = SETTLE_CYCLES+2 cycles.

States:
- IDLE: A_OUT=B_OUT=0.
  - START=1 -> clear FAIL_MASK, ERR_CNT, PASS, FIRST_FAIL_VEC; vec=0; go to DRIVE.
  - BUSY rises in the next cycle.
- DRIVE (1 cycle): A_OUT<=vec[7:4], B_OUT<=vec[3:0]; load the wait counter; go to WAIT.
- WAIT (SETTLE_CYCLES+2 cycles): count down; at zero go to CHECK.
- CHECK (1 cycle): compute mis = Ysync ^ (A_OUT|B_OUT).
  - FAIL_MASK |= mis.
  - If mis != 0, ERR_CNT increments, saturating at all-ones.
  - If vec==255 go to REPORT; else vec++ and go to DRIVE.
- REPORT (1 cycle): DONE=1; PASS=(FAIL_MASK==0), including the final CHECK's contribution; BUSY=0; go to IDLE.

Timing:
- Cycles per vector = SETTLE_CYCLES+4.
- DONE occurs 256*(SETTLE_CYCLES+4)+1 cycles after the START cycle (default 1537).

Boundary cases:
- START while BUSY or in REPORT: ignored.
- START and ABORT together in IDLE: ABORT wins; stay IDLE.
- ABORT in any non-IDLE state: next state IDLE; A_OUT/B_OUT=0; BUSY=0; no DONE; PASS=0; FAIL_MASK and ERR_CNT keep their partial values.
- vec is 8 bits with no wrap: the terminal check at 255 precedes the increment.
- ERR_CNT saturates and never wraps (maximum real count is 256; matters when ERR_W<9).
- Reset mid-run: immediate return to reset values; no DONE.

Optional Feature:
- Macro: HC32_TESTER_FIRST_FAIL_EN.
- Defined: FIRST_FAIL_VEC captures vec at the first CHECK with mis != 0 and holds it until the next START. A sticky flag blocks later captures.
- Undefined: FIRST_FAIL_VEC is tied to 0 and the capture logic is absent.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package hc32_pkg holds:
  - state enum (IDLE, DRIVE, WAIT, CHECK, REPORT)
  - NUM_GATES=4
  - VEC_LAST=8'hFF
  - default SETTLE_CYCLES
- One sub-module: hc32_sync2, a 4-bit two-flop synchronizer with async active-low reset, instantiated on Y_IN.
- FSM, counters and scoreboard stay in hc32_tester.

Test Plan:
- Golden: loop Y_IN=A_OUT|B_OUT (model delay 1 cycle), START pulse -> DONE at cycle 1537, PASS=1, FAIL_MASK=0, ERR_CNT=0.
- Stuck-at-0 on gate 3 (Y_IN[3]=0) -> PASS=0, FAIL_MASK=4'b0100, ERR_CNT=192, FIRST_FAIL_VEC=8'h04 (macro on) / 8'h00 (macro off).
- Stuck-at-1 on gate 1 -> FAIL_MASK=4'b0001, ERR_CNT=64, FIRST_FAIL_VEC=8'h00 (macro on).
- ABORT at cycle 500 -> BUSY=0 next cycle, A_OUT=B_OUT=0, no DONE pulse, PASS=0; a second START then runs clean to DONE with PASS=1.
- START re-pulsed at cycle 100 while BUSY -> ignored; DONE still at 1537, exactly one DONE pulse.
- RST_N low at cycle 800 -> all outputs 0 asynchronously; after release, IDLE with BUSY=0 until START.

Source files
------------

// File: rtl/hc32_pkg.sv
// Shared types and constants for the HC32 quad OR-gate self-test sequencer.
package hc32_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    WAIT   = 3'd2,
    CHECK  = 3'd3,
    REPORT = 3'd4
  } state_e;

  localparam int         NUM_GATES         = 4;
  localparam logic [7:0] VEC_LAST          = 8'hFF;
  localparam int         SETTLE_CYCLES_DEF = 2;

endpackage

// File: rtl/hc32_sync2.sv
// Two-flop synchronizer for the gate outputs, which may come straight from board pins.
module hc32_sync2
  import hc32_pkg::*;
#(
  parameter int W = NUM_GATES
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/hc32_tester.sv
// HC32 self-test sequencer: sweeps all 256 A/B vectors, checks Y against A|B, reports pass/fail.
// Optional first-failing-vector capture is enabled by defining HC32_TESTER_FIRST_FAIL_EN.
module hc32_tester
  import hc32_pkg::*;
#(
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int ERR_W         = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             ABORT,
  output logic [4:1]       A_OUT,
  output logic [4:1]       B_OUT,
  input  logic [4:1]       Y_IN,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [4:1]       FAIL_MASK,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic [7:0]       FIRST_FAIL_VEC
);

  // Two synchronizer cycles plus the settle interval all elapse inside WAIT.
  localparam logic [4:0] WAIT_LOAD = 5'(SETTLE_CYCLES + 1);

  state_e           state_q;
  logic [7:0]       vec_q;
  logic [4:0]       wait_cnt_q;
  logic [4:1]       a_q;
  logic [4:1]       b_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [4:1]       fail_mask_q;
  logic [ERR_W-1:0] err_cnt_q;

  logic [NUM_GATES-1:0] y_sync;
  logic [4:1]           mis_d;
  logic [ERR_W-1:0]     err_cnt_d;
  logic                 start_accept;
  logic                 abort_act;

  hc32_sync2 #(.W(NUM_GATES)) u_sync (
    .clk_i   (CLK),
    .rst_n_i (RST_N),
    .d_i     (Y_IN),
    .q_o     (y_sync)
  );

  assign mis_d        = y_sync ^ (a_q | b_q);
  assign err_cnt_d    = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + ERR_W'(1);
  assign start_accept = (state_q == IDLE) && START && !ABORT;
  assign abort_act    = (state_q != IDLE) && ABORT;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      vec_q       <= '0;
      wait_cnt_q  <= '0;
      a_q         <= '0;
      b_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_mask_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (abort_act) begin
        // Partial FAIL_MASK/ERR_CNT are deliberately kept for post-mortem.
        state_q <= IDLE;
        a_q     <= '0;
        b_q     <= '0;
        busy_q  <= 1'b0;
        pass_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start_accept) begin
              fail_mask_q <= '0;
              err_cnt_q   <= '0;
              pass_q      <= 1'b0;
              vec_q       <= '0;
              busy_q      <= 1'b1;
              state_q     <= DRIVE;
            end
          end
          DRIVE: begin
            a_q        <= vec_q[7:4];
            b_q        <= vec_q[3:0];
            wait_cnt_q <= WAIT_LOAD;
            state_q    <= WAIT;
          end
          WAIT: begin
            if (wait_cnt_q == '0) state_q <= CHECK;
            else                  wait_cnt_q <= wait_cnt_q - 5'd1;
          end
          CHECK: begin
            fail_mask_q <= fail_mask_q | mis_d;
            if (mis_d != '0) err_cnt_q <= err_cnt_d;
            // Terminal test precedes the increment so vec never wraps.
            if (vec_q == VEC_LAST) begin
              state_q <= REPORT;
            end else begin
              vec_q   <= vec_q + 8'd1;
              state_q <= DRIVE;
            end
          end
          REPORT: begin
            done_q  <= 1'b1;
            pass_q  <= (fail_mask_q == '0);
            busy_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

`ifdef HC32_TESTER_FIRST_FAIL_EN
  logic [7:0] first_fail_q;
  logic       first_seen_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      first_fail_q <= '0;
      first_seen_q <= 1'b0;
    end else if (start_accept) begin
      first_fail_q <= '0;
      first_seen_q <= 1'b0;
    end else if (!abort_act && (state_q == CHECK) && (mis_d != '0) && !first_seen_q) begin
      first_fail_q <= vec_q;
      first_seen_q <= 1'b1;
    end
  end

  assign FIRST_FAIL_VEC = first_fail_q;
`else
  assign FIRST_FAIL_VEC = 8'h00;
`endif

  assign A_OUT     = a_q;
  assign B_OUT     = b_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign PASS      = pass_q;
  assign FAIL_MASK = fail_mask_q;
  assign ERR_CNT   = err_cnt_q;

endmodule

// File: tb/tb_hc32_tester.sv
// Self-checking bench for hc32_tester: fault-injecting gate model plus a vector-sweep reference model.
module tb_hc32_tester;

  localparam int SETTLE  = 2;
  localparam int ERR_W   = 8;
  localparam int NVEC    = 256;
  localparam int RUN_LEN = NVEC * (SETTLE + 4) + 1;
  localparam int MAXC    = RUN_LEN + 10;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [4:1]       y_in  = '0;
  logic [4:1]       a_out, b_out, fail_mask;
  logic             busy, done, pass;
  logic [ERR_W-1:0] err_cnt;
  logic [7:0]       first_fail;

  int checks = 0;
  int errors = 0;

  // Fault configuration of the simulated gate array
  logic [3:0] s0 = '0;
  logic [3:0] s1 = '0;
  logic [3:0] flip_tbl [NVEC];

  hc32_tester #(.SETTLE_CYCLES(SETTLE), .ERR_W(ERR_W)) dut (
    .CLK            (clk),
    .RST_N          (rst_n),
    .START          (start),
    .ABORT          (abort),
    .A_OUT          (a_out),
    .B_OUT          (b_out),
    .Y_IN           (y_in),
    .BUSY           (busy),
    .DONE           (done),
    .PASS           (pass),
    .FAIL_MASK      (fail_mask),
    .ERR_CNT        (err_cnt),
    .FIRST_FAIL_VEC (first_fail)
  );

  always #5 clk = ~clk;

  // Gate array with one cycle of propagation delay and injected faults
  always @(posedge clk)
    y_in <= (((a_out | b_out) & ~s0) | s1) ^ flip_tbl[{a_out, b_out}];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: sweep the first nvec vectors and apply the OR-gate rule directly.
  task automatic model(input int nvec, output logic [3:0] m, output int e, output logic [7:0] ff);
    int cnt, g, y, mis;
    logic any;
    m = '0; ff = '0; any = 1'b0; cnt = 0;
    for (int v = 0; v < nvec; v++) begin
      g   = (v >> 4) | (v & 15);
      y   = ((g & ~int'(s0)) | int'(s1)) ^ int'(flip_tbl[v]);
      mis = (y ^ g) & 15;
      if (mis != 0) begin
        m = m | 4'(mis);
        cnt++;
        if (!any) begin
          ff  = 8'(v);
          any = 1'b1;
        end
      end
    end
    e = (cnt > (1 << ERR_W) - 1) ? (1 << ERR_W) - 1 : cnt;
  endtask

  task automatic check_result(input string tag, input int nvec);
    logic [3:0] m;
    int e;
    logic [7:0] ff;
    model(nvec, m, e, ff);
`ifndef HC32_TESTER_FIRST_FAIL_EN
    ff = 8'h00;
`endif
    check({tag, " mask"}, 32'(fail_mask), 32'(m));
    check({tag, " err"}, 32'(err_cnt), 32'(e));
    check({tag, " first"}, 32'(first_fail), 32'(ff));
  endtask

  // Pulse START, then watch for max_cyc cycles with optional restart/abort/reset events.
  task automatic do_run(input int restart_at, input int abort_at, input int reset_at,
                        output int done_cyc, output int done_cnt,
                        output logic busy1, output logic [30:0] snap);
    done_cyc = -1; done_cnt = 0; busy1 = 1'b0; snap = '1;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int n = 1; n <= MAXC; n++) begin
      @(posedge clk); #1;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = n;
      end
      if (n == 1) busy1 = busy;
      if (n == abort_at) begin
        snap  = {a_out, b_out, busy, done, pass, fail_mask, err_cnt, first_fail};
        abort = 1'b0;
      end
      if (n == reset_at) begin
        rst_n = 1'b0;
        #1 snap = {a_out, b_out, busy, done, pass, fail_mask, err_cnt, first_fail};
      end
      if (n == reset_at + 3) rst_n = 1'b1;
      if (n == abort_at - 1) abort = 1'b1;
      if (n == restart_at - 1) start = 1'b1;
      if (n == restart_at) start = 1'b0;
    end
  endtask

  task automatic clear_faults();
    s0 = '0; s1 = '0;
    for (int v = 0; v < NVEC; v++) flip_tbl[v] = '0;
  endtask

  task automatic full_run(input string tag, input logic exp_pass);
    int dc, dn;
    logic b1;
    logic [30:0] sn;
    do_run(-1, -1, -1, dc, dn, b1, sn);
    $display("run %s: done_at=%0d pulses=%0d pass=%0b mask=%b err=%0d first=%02h",
             tag, dc, dn, pass, fail_mask, err_cnt, first_fail);
    check({tag, " done_at"}, 32'(dc), 32'(RUN_LEN));
    check({tag, " pulses"}, 32'(dn), 32'd1);
    check({tag, " busy1"}, 32'(b1), 32'd1);
    check({tag, " busy_end"}, 32'(busy), 32'd0);
    check({tag, " pass"}, 32'(pass), 32'(exp_pass));
    check_result(tag, NVEC);
  endtask

  initial begin
    int dc, dn;
    logic b1;
    logic [30:0] sn;

    clear_faults();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset outs", 32'({a_out, b_out, busy, done, pass, fail_mask, err_cnt, first_fail}), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    full_run("golden", 1'b1);

    clear_faults(); s0 = 4'b0100;
    full_run("stuck0_g3", 1'b0);
    check("stuck0_g3 err const", 32'(err_cnt), 32'd192);
    check("stuck0_g3 mask const", 32'(fail_mask), 32'h4);

    clear_faults(); s1 = 4'b0001;
    full_run("stuck1_g1", 1'b0);
    check("stuck1_g1 err const", 32'(err_cnt), 32'd64);

    clear_faults(); flip_tbl[255] = 4'b1000;
    full_run("last_vec", 1'b0);

    clear_faults();
    for (int v = 0; v < NVEC; v++) flip_tbl[v] = 4'($urandom_range(1, 15));
    full_run("saturate", 1'b0);

    for (int r = 0; r < 3; r++) begin
      clear_faults();
      s0 = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      s1 = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)) & ~s0;
      for (int v = 0; v < NVEC; v++)
        flip_tbl[v] = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      full_run($sformatf("random%0d", r), 1'b0);
    end

    clear_faults();
    full_run("golden2", 1'b1);

    // Abort mid-run: checks happen every SETTLE+4 cycles, so 500/(SETTLE+4) vectors are done.
    clear_faults(); s1 = 4'b0001;
    do_run(-1, 500, -1, dc, dn, b1, sn);
    $display("run abort: pulses=%0d busy=%0b pass=%0b mask=%b err=%0d", dn, busy, pass, fail_mask, err_cnt);
    check("abort outs", 32'(sn[30:20]), 32'd0);
    check("abort pulses", 32'(dn), 32'd0);
    check("abort busy_end", 32'(busy), 32'd0);
    check("abort pass", 32'(pass), 32'd0);
    check_result("abort partial", 500 / (SETTLE + 4));

    clear_faults();
    full_run("after_abort", 1'b1);

    do_run(100, -1, -1, dc, dn, b1, sn);
    $display("run restart: done_at=%0d pulses=%0d pass=%0b", dc, dn, pass);
    check("restart done_at", 32'(dc), 32'(RUN_LEN));
    check("restart pulses", 32'(dn), 32'd1);
    check("restart pass", 32'(pass), 32'd1);

    clear_faults(); s0 = 4'b0100;
    do_run(-1, -1, 800, dc, dn, b1, sn);
    $display("run reset: pulses=%0d busy=%0b snap=%h", dn, busy, sn);
    check("reset mid outs", 32'(sn), 32'd0);
    check("reset mid pulses", 32'(dn), 32'd0);
    check("reset mid busy_end", 32'(busy), 32'd0);
    check("reset mid a_out", 32'(a_out), 32'd0);

    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("run start_abort: busy=%0b a=%b b=%b", busy, a_out, b_out);
    check("start_abort busy", 32'(busy), 32'd0);
    check("start_abort a_out", 32'(a_out), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
